// File: rtl/checkpoint_seq_monitor_pkg.sv
// Shared types and helpers for the checkpoint sequence monitor.
package checkpoint_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      PASS  = 2'd2,
      FAIL  = 2'd3
   } mon_state_t;

   // Bits needed to index 'value' items; 0 when value <= 1.
   function automatic int cm_clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/checkpoint_seq_monitor_if.sv
// Control, configuration and status bundle of the checkpoint sequence monitor.
interface checkpoint_seq_monitor_if #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 8
) ();
   import checkpoint_mon_pkg::*;

   localparam int AW = cm_clog2(DEPTH);

   logic             start;
   logic             abort;
   logic [WIDTH-1:0] probe;
   logic             cfg_we;
   logic [AW-1:0]    cfg_addr;
   logic [WIDTH-1:0] cfg_data;
   logic [AW:0]      cfg_len;
   logic             busy;
   logic             step_pulse;
   logic [AW-1:0]    step_idx;
   logic             done;
   logic             pass;
   logic             fail;
   logic             timeout;
   logic [WIDTH-1:0] err_value;

   modport master (
      output start, abort, probe, cfg_we, cfg_addr, cfg_data, cfg_len,
      input  busy, step_pulse, step_idx, done, pass, fail, timeout, err_value
   );

   modport slave (
      input  start, abort, probe, cfg_we, cfg_addr, cfg_data, cfg_len,
      output busy, step_pulse, step_idx, done, pass, fail, timeout, err_value
   );

endinterface

// File: rtl/checkpoint_seq_monitor_sync.sv
// Two-flop synchroniser plus debounce: a value is taken only after STABLE equal samples.
module cm_sync_filter
   import checkpoint_mon_pkg::*;
#(
   parameter int WIDTH  = 2,
   parameter int STABLE = 2
) (
   input  logic             clock,
   input  logic             RSTB,
   input  logic [WIDTH-1:0] probe,
   output logic [WIDTH-1:0] value,
   output logic             new_value
);
   localparam int CW = cm_clog2(STABLE + 1);

   logic [WIDTH-1:0] sync1_reg, sync2_reg, last_reg, value_reg;
   logic [CW-1:0]    count_reg, count_next;
   logic             new_value_reg;

   // Run length of the current synchronised value, saturating at STABLE.
   always_comb begin
      count_next = count_reg;
      if (sync2_reg != last_reg)
         count_next = CW'(1);
      else if (count_reg != CW'(STABLE))
         count_next = count_reg + 1'b1;
   end

   always_ff @(posedge clock or negedge RSTB) begin
      if (!RSTB) begin
         sync1_reg     <= '0;
         sync2_reg     <= '0;
         last_reg      <= '0;
         value_reg     <= '0;
         count_reg     <= '0;
         new_value_reg <= 1'b0;
      end else begin
         sync1_reg     <= probe;
         sync2_reg     <= sync1_reg;
         last_reg      <= sync2_reg;
         count_reg     <= count_next;
         new_value_reg <= 1'b0;
         if (count_next == CW'(STABLE) && sync2_reg != value_reg) begin
            value_reg     <= sync2_reg;
            new_value_reg <= 1'b1;
         end
      end
   end

   assign value     = value_reg;
   assign new_value = new_value_reg;

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Matches the debounced checkpoint bus against a programmable ordered table.
module checkpoint_seq_monitor
   import checkpoint_mon_pkg::*;
#(
   parameter int WIDTH   = 2,
   parameter int DEPTH   = 8,
   parameter int STABLE  = 2,
   parameter int TIMEOUT = 50000,
   parameter int STRICT  = 0
) (
   input logic clock,
   input logic RSTB,
   checkpoint_seq_monitor_if.slave bus
);
   localparam int AW     = cm_clog2(DEPTH);
   localparam int LW     = AW + 1;
   localparam int TW_RAW = cm_clog2(TIMEOUT + 1);
   localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
   localparam logic [TW-1:0] T_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   mon_state_t state_reg, state_next;

   logic [DEPTH-1:0][WIDTH-1:0] table_reg;
   logic [AW-1:0]    idx_reg, step_idx_reg;
   logic [LW-1:0]    len_reg;
   logic [TW-1:0]    timer_reg;
   logic [WIDTH-1:0] err_value_reg, filt_value;
   logic             consumed_reg, step_pulse_reg, timeout_reg, filt_new;
   logic             fresh, hit, strict_err, timer_expired, last_entry;
   logic [WIDTH-1:0] exp_cur, exp_prev;

   cm_sync_filter #(.WIDTH(WIDTH), .STABLE(STABLE)) u_filter (
      .clock     (clock),
      .RSTB      (RSTB),
      .probe     (bus.probe),
      .value     (filt_value),
      .new_value (filt_new)
   );

   // The table is frozen while a run is in progress.
   always_ff @(posedge clock or negedge RSTB) begin
      if (!RSTB)
         table_reg <= '0;
      else if (bus.cfg_we && state_reg != ARMED && 32'(bus.cfg_addr) < DEPTH)
         table_reg[bus.cfg_addr] <= bus.cfg_data;
   end

   assign exp_cur  = table_reg[idx_reg];
   assign exp_prev = table_reg[idx_reg - 1'b1];

   always_ff @(posedge clock or negedge RSTB) begin
      if (!RSTB) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // A value is eligible once per appearance: right after arming or after it changes.
   always_comb begin
      state_next    = state_reg;
      fresh         = filt_new || !consumed_reg;
      hit           = 1'b0;
      strict_err    = 1'b0;
      timer_expired = 1'b0;
      last_entry    = ({1'b0, idx_reg} == len_reg - 1'b1);
      if (bus.abort) begin
         state_next = IDLE;
      end else if (state_reg == ARMED) begin
         if (fresh && filt_value == exp_cur) begin
            hit = 1'b1;
            if (last_entry) state_next = PASS;
         end else if (STRICT != 0 && fresh && idx_reg != '0 && filt_value != exp_prev) begin
            strict_err = 1'b1;
            state_next = FAIL;
         end else if (TIMEOUT != 0 && timer_reg == T_LAST) begin
            timer_expired = 1'b1;
            state_next    = FAIL;
         end
      end else if (bus.start) begin
         state_next = ARMED;
      end
   end

   always_ff @(posedge clock or negedge RSTB) begin
      if (!RSTB) begin
         idx_reg        <= '0;
         len_reg        <= '0;
         timer_reg      <= '0;
         consumed_reg   <= 1'b0;
         step_pulse_reg <= 1'b0;
         step_idx_reg   <= '0;
         timeout_reg    <= 1'b0;
         err_value_reg  <= '0;
      end else begin
         step_pulse_reg <= 1'b0;
         if (bus.abort) begin
            step_idx_reg  <= '0;
            timeout_reg   <= 1'b0;
            err_value_reg <= '0;
         end else if (state_reg != ARMED && bus.start) begin
            idx_reg       <= '0;
            timer_reg     <= '0;
            consumed_reg  <= 1'b0;
            step_idx_reg  <= '0;
            timeout_reg   <= 1'b0;
            err_value_reg <= '0;
            len_reg       <= (bus.cfg_len == '0 || bus.cfg_len > DEPTH_L) ? DEPTH_L : bus.cfg_len;
         end else if (state_reg == ARMED) begin
            if (filt_new) consumed_reg <= 1'b0;
            if (hit) begin
               step_pulse_reg <= 1'b1;
               step_idx_reg   <= idx_reg;
               timer_reg      <= '0;
               consumed_reg   <= 1'b1;
               if (!last_entry) idx_reg <= idx_reg + 1'b1;
            end else if (strict_err) begin
               err_value_reg <= filt_value;
            end else if (timer_expired) begin
               timeout_reg   <= 1'b1;
               err_value_reg <= filt_value;
            end else if (timer_reg != {TW{1'b1}}) begin
               timer_reg <= timer_reg + 1'b1;
            end
         end
      end
   end

   assign bus.busy       = (state_reg == ARMED);
   assign bus.done       = (state_reg == PASS) || (state_reg == FAIL);
   assign bus.pass       = (state_reg == PASS);
   assign bus.fail       = (state_reg == FAIL);
   assign bus.step_pulse = step_pulse_reg;
   assign bus.step_idx   = step_idx_reg;
   assign bus.timeout    = timeout_reg;
   assign bus.err_value  = err_value_reg;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Drives a lenient and a strict monitor with the same stimulus and checks both against a sequence model.
module tb_checkpoint_seq_monitor;
   localparam int WIDTH   = 2;
   localparam int DEPTH   = 8;
   localparam int STABLE  = 2;
   localparam int TIMEOUT = 100;

   logic       clock = 1'b0;
   logic       RSTB;
   logic       start = 0, abort = 0, cfg_we = 0;
   logic [1:0] probe = 0, cfg_data = 0;
   logic [2:0] cfg_addr = 0;
   logic [3:0] cfg_len = 0;

   always #5 clock = ~clock;

   checkpoint_seq_monitor_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_l ();
   checkpoint_seq_monitor_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_s ();

   assign bus_l.start = start;   assign bus_s.start = start;
   assign bus_l.abort = abort;   assign bus_s.abort = abort;
   assign bus_l.probe = probe;   assign bus_s.probe = probe;
   assign bus_l.cfg_we = cfg_we; assign bus_s.cfg_we = cfg_we;
   assign bus_l.cfg_addr = cfg_addr; assign bus_s.cfg_addr = cfg_addr;
   assign bus_l.cfg_data = cfg_data; assign bus_s.cfg_data = cfg_data;
   assign bus_l.cfg_len = cfg_len;   assign bus_s.cfg_len = cfg_len;

   checkpoint_seq_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STABLE(STABLE), .TIMEOUT(TIMEOUT), .STRICT(0))
      u_lax (.clock(clock), .RSTB(RSTB), .bus(bus_l));
   checkpoint_seq_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STABLE(STABLE), .TIMEOUT(TIMEOUT), .STRICT(1))
      u_strict (.clock(clock), .RSTB(RSTB), .bus(bus_s));

   int n_checks = 0, n_pass = 0, cyc = 0;

   // ---------------- behavioural model (index 0 = lenient, 1 = strict) ----------------
   int         hist [STABLE+2];
   bit [1:0]   m_filt;
   bit         m_newv;
   bit [1:0]   m_tbl [2][DEPTH];
   bit         m_busy[2], m_pass[2], m_fail[2], m_to[2], m_sp[2], m_used[2];
   int         m_idx[2], m_timer[2], m_len[2], m_sidx[2], m_err[2];

   function automatic void model_reset();
      for (int i = 0; i < STABLE + 2; i++) hist[i] = 0;
      m_filt = 0; m_newv = 0;
      for (int k = 0; k < 2; k++) begin
         for (int a = 0; a < DEPTH; a++) m_tbl[k][a] = 0;
         m_busy[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_to[k] = 0; m_sp[k] = 0; m_used[k] = 0;
         m_idx[k] = 0; m_timer[k] = 0; m_len[k] = 0; m_sidx[k] = 0; m_err[k] = 0;
      end
   endfunction

   function automatic void model_top(input int k);
      bit pre_busy, fresh;
      pre_busy = m_busy[k];
      m_sp[k] = 0;
      if (abort) begin
         m_busy[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_to[k] = 0; m_err[k] = 0; m_sidx[k] = 0;
      end else if (!pre_busy && start) begin
         m_busy[k] = 1; m_pass[k] = 0; m_fail[k] = 0; m_to[k] = 0; m_err[k] = 0; m_sidx[k] = 0;
         m_idx[k] = 0; m_timer[k] = 0; m_used[k] = 0;
         m_len[k] = (cfg_len == 0 || int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
      end else if (pre_busy) begin
         fresh = m_newv || !m_used[k];
         if (m_newv) m_used[k] = 0;
         if (fresh && m_filt == m_tbl[k][m_idx[k]]) begin
            m_sp[k] = 1; m_sidx[k] = m_idx[k]; m_timer[k] = 0; m_used[k] = 1;
            if (m_idx[k] == m_len[k] - 1) begin m_busy[k] = 0; m_pass[k] = 1; end
            else m_idx[k]++;
         end else if (k == 1 && fresh && m_idx[k] > 0 && m_filt != m_tbl[k][m_idx[k]-1]) begin
            m_busy[k] = 0; m_fail[k] = 1; m_err[k] = m_filt;
         end else if (m_timer[k] == TIMEOUT - 1) begin
            m_busy[k] = 0; m_fail[k] = 1; m_to[k] = 1; m_err[k] = m_filt;
         end else begin
            m_timer[k]++;
         end
      end
      if (cfg_we && !pre_busy) m_tbl[k][cfg_addr] = cfg_data;
   endfunction

   // Filtered value = the synchronised sample once it has been seen STABLE times in a row.
   function automatic void model_filter();
      bit steady;
      for (int i = STABLE + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = probe;
      m_newv = 0;
      steady = 1;
      for (int i = 3; i <= STABLE + 1; i++) if (hist[i] != hist[2]) steady = 0;
      if (steady && 2'(hist[2]) != m_filt) begin m_filt = 2'(hist[2]); m_newv = 1; end
   endfunction

   always @(negedge RSTB) model_reset();

   always @(posedge clock) begin
      cyc++;
      if (RSTB === 1'b1) begin
         for (int k = 0; k < 2; k++) model_top(k);
         model_filter();
      end
   end

   // ---------------- checking ----------------
   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
   endfunction

   int sp_cnt[2], step2_cyc[2], fail_cyc[2];
   bit prev_fail[2];

   task automatic cmp(input int k, input logic b, input logic sp, input logic [2:0] si, input logic d,
                      input logic p, input logic f, input logic to, input logic [1:0] ev);
      logic [11:0] got_v, exp_v;
      got_v = {b, sp, si, d, p, f, to, ev};
      exp_v = {m_busy[k], m_sp[k], 3'(m_sidx[k]), m_pass[k] | m_fail[k], m_pass[k], m_fail[k], m_to[k], 2'(m_err[k])};
      n_checks++;
      if (got_v === exp_v) n_pass++;
      else $display("FAIL outputs inst=%0d t=%0t got busy=%b step=%b idx=%0d done=%b pass=%b fail=%b to=%b err=%0d want busy=%b step=%b idx=%0d done=%b pass=%b fail=%b to=%b err=%0d",
                    k, $time, b, sp, si, d, p, f, to, ev, exp_v[11], exp_v[10], exp_v[9:7], exp_v[6], exp_v[5], exp_v[4], exp_v[3], exp_v[1:0]);
      if (sp === 1'b1) sp_cnt[k]++;
      if (sp === 1'b1 && si == 3'd2) step2_cyc[k] = cyc;
      if (f === 1'b1 && !prev_fail[k]) fail_cyc[k] = cyc;
      prev_fail[k] = (f === 1'b1);
   endtask

   always @(negedge clock) begin
      cmp(0, bus_l.busy, bus_l.step_pulse, bus_l.step_idx, bus_l.done, bus_l.pass, bus_l.fail, bus_l.timeout, bus_l.err_value);
      cmp(1, bus_s.busy, bus_s.step_pulse, bus_s.step_idx, bus_s.done, bus_s.pass, bus_s.fail, bus_s.timeout, bus_s.err_value);
   end

   // ---------------- stimulus ----------------
   logic [1:0] seq5 [5];

   task automatic cyc1(); @(posedge clock); #2; endtask
   task automatic hold(input logic [1:0] v, input int n); probe = v; repeat (n) cyc1(); endtask
   task automatic pulse_start(); start = 1; cyc1(); start = 0; endtask
   task automatic pulse_abort(); abort = 1; cyc1(); abort = 0; endtask
   task automatic write_entry(input logic [2:0] a, input logic [1:0] d);
      cfg_we = 1; cfg_addr = a; cfg_data = d; cyc1(); cfg_we = 0;
   endtask
   task automatic run_seq5(); for (int i = 0; i < 5; i++) hold(seq5[i], 10); endtask
   task automatic clear_counts(); sp_cnt[0] = 0; sp_cnt[1] = 0; endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy_l"}, int'(bus_l.busy), 0);   check({tag, "_busy_s"}, int'(bus_s.busy), 0);
      check({tag, "_done_l"}, int'(bus_l.done), 0);   check({tag, "_done_s"}, int'(bus_s.done), 0);
      check({tag, "_fail_s"}, int'(bus_s.fail), 0);   check({tag, "_to_l"}, int'(bus_l.timeout), 0);
      check({tag, "_pass_l"}, int'(bus_l.pass), 0);   check({tag, "_step_s"}, int'(bus_s.step_pulse), 0);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int hold_left;
      seq5 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      RSTB = 1'b1;
      #1 RSTB = 1'b0;
      repeat (3) cyc1();
      check_idle("reset");
      RSTB = 1'b1;
      cyc1();

      // Full 0-1-2-3-0 sequence
      for (int i = 0; i < 5; i++) write_entry(3'(i), seq5[i]);
      cfg_len = 4'd5;
      clear_counts();
      pulse_start();
      run_seq5();
      check("t1_steps_l", sp_cnt[0], 5);  check("t1_steps_s", sp_cnt[1], 5);
      check("t1_pass_l", int'(bus_l.pass), 1); check("t1_pass_s", int'(bus_s.pass), 1);
      check("t1_idx_l", int'(bus_l.step_idx), 4);
      check("t1_model_pass", int'(m_pass[0]), 1);

      // Stall on 2 until the timer expires
      step2_cyc = '{-1, -1}; fail_cyc = '{-1, -1};
      pulse_start();
      hold(0, 10); hold(1, 10); hold(2, 150);
      check("t2_delay_l", fail_cyc[0] - step2_cyc[0], 100);
      check("t2_delay_s", fail_cyc[1] - step2_cyc[1], 100);
      check("t2_timeout_l", int'(bus_l.timeout), 1); check("t2_timeout_s", int'(bus_s.timeout), 1);
      check("t2_fail_l", int'(bus_l.fail), 1);
      check("t2_model_to", int'(m_to[1]), 1);

      // Out-of-order 3 after 0,1
      pulse_start();
      hold(0, 10); hold(1, 10); hold(3, 10);
      check("t3_fail_s", int'(bus_s.fail), 1); check("t3_err_s", int'(bus_s.err_value), 3);
      check("t3_to_s", int'(bus_s.timeout), 0);
      check("t3_fail_l", int'(bus_l.fail), 0); check("t3_busy_l", int'(bus_l.busy), 1);

      // One-cycle glitch 1->2->1 must not be accepted
      pulse_abort();
      check_idle("t4_abort");
      pulse_start();
      hold(0, 10); hold(1, 10);
      clear_counts();
      hold(2, 1); hold(1, 12);
      check("t4_glitch_l", sp_cnt[0], 0); check("t4_glitch_s", sp_cnt[1], 0);
      check("t4_idx_s", int'(bus_s.step_idx), 1);

      // Abort at idx 2, then a clean restart
      hold(2, 10);
      check("t5_idx_l", int'(bus_l.step_idx), 2);
      pulse_abort();
      check_idle("t5_abort");
      clear_counts();
      pulse_start();
      run_seq5();
      check("t5_steps_l", sp_cnt[0], 5); check("t5_pass_s", int'(bus_s.pass), 1);

      // Asynchronous reset mid-run
      pulse_start();
      hold(0, 10); hold(1, 10);
      check("t6_busy_l", int'(bus_l.busy), 1); check("t6_busy_s", int'(bus_s.busy), 1);
      #1 RSTB = 1'b0;
      #1 check_idle("t6_async");
      check("t6_idx_l", int'(bus_l.step_idx), 0);
      repeat (3) cyc1();
      RSTB = 1'b1;

      // Table write while busy is dropped
      write_entry(3'd0, 2'd1); write_entry(3'd1, 2'd2);
      cfg_len = 4'd2;
      hold(3, 10);
      pulse_start();
      write_entry(3'd1, 2'd3);
      hold(1, 10); hold(2, 10);
      check("t7_pass_l", int'(bus_l.pass), 1); check("t7_pass_s", int'(bus_s.pass), 1);

      // Randomised traffic against the model
      hold_left = 0;
      for (int c = 0; c < 3000; c++) begin
         start    = ($urandom_range(0, 29) == 0);
         abort    = ($urandom_range(0, 149) == 0);
         cfg_we   = ($urandom_range(0, 7) == 0);
         cfg_addr = 3'($urandom_range(0, 7));
         cfg_data = 2'($urandom_range(0, 3));
         cfg_len  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(2, 4));
         if (hold_left == 0) begin
            probe     = 2'($urandom_range(0, 3));
            hold_left = $urandom_range(1, 12);
         end
         hold_left--;
         cyc1();
      end
      start = 0; abort = 0; cfg_we = 0;
      repeat (5) cyc1();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
